// File: rtl/motion_segment_sequencer.sv
// Segment queue that feeds acc_profile_gen: loads each queued v/a/j segment and paces acc_step.
// Optional MOTION_SEQ_AUTOSTOP_EN zeroes the generator on queue exhaustion and on abort.
module motion_segment_sequencer #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          seg_wr,
  input  logic [2:0]    seg_flags,
  input  logic [31:0]   seg_v,
  input  logic [31:0]   seg_a,
  input  logic [31:0]   seg_j,
  input  logic [31:0]   seg_dur,
  output logic          seg_full,
  output logic [AW:0]   seg_count,
  input  logic          start,
  input  logic          abort,
  input  logic          set_pos,
  input  logic [63:0]   pos_val,
  input  logic [15:0]   acc_div,
  output logic          busy,
  output logic          done,
  output logic          load,
  output logic          set_x,
  output logic          set_v,
  output logic          set_a,
  output logic          set_j,
  output logic [63:0]   x_val,
  output logic [31:0]   v_val,
  output logic [31:0]   a_val,
  output logic [31:0]   j_val,
  output logic          acc_step
);

`ifdef MOTION_SEQ_AUTOSTOP_EN
  localparam bit AutoStop = 1'b1;
`else
  localparam bit AutoStop = 1'b0;
`endif

  localparam logic [AW:0] FullCount = (AW+1)'(DEPTH);
  localparam logic [AW:0] OneCount  = (AW+1)'(1);

  typedef enum logic [1:0] {StIdle, StLoad, StRun, StEnd} state_e;

  state_e         state_q, state_d;
  logic [31:0]    rem_q, rem_d;
  logic [15:0]    div_q, div_d;
  logic [15:0]    presc_q, presc_d;
  logic [AW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [AW:0]    count_q, count_d;

  logic [2:0]     flags_mem [DEPTH];
  logic [31:0]    v_mem     [DEPTH];
  logic [31:0]    a_mem     [DEPTH];
  logic [31:0]    j_mem     [DEPTH];
  logic [31:0]    dur_mem   [DEPTH];

  logic           push, pop, flush, full;
  logic           load_d, set_x_d, set_v_d, set_a_d, set_j_d, acc_step_d, done_d;
  logic [63:0]    x_val_d;
  logic [31:0]    v_val_d, a_val_d, j_val_d;

  assign full      = (count_q == FullCount);
  assign push      = seg_wr && !abort && (!full || pop);
  assign seg_count = count_q;

  always_ff @(posedge clk) begin
    if (push) begin
      flags_mem[wr_ptr_q] <= seg_flags;
      v_mem[wr_ptr_q]     <= seg_v;
      a_mem[wr_ptr_q]     <= seg_a;
      j_mem[wr_ptr_q]     <= seg_j;
      dur_mem[wr_ptr_q]   <= seg_dur;
    end
  end

  always_comb begin
    count_d = count_q;
    if (flush) begin
      count_d = '0;
    end else if (push && !pop) begin
      count_d = count_q + OneCount;
    end else if (pop && !push) begin
      count_d = count_q - OneCount;
    end
  end

  always_comb begin
    state_d    = state_q;
    rem_d      = rem_q;
    div_d      = div_q;
    presc_d    = presc_q;
    pop        = 1'b0;
    flush      = 1'b0;
    load_d     = 1'b0;
    set_x_d    = 1'b0;
    set_v_d    = 1'b0;
    set_a_d    = 1'b0;
    set_j_d    = 1'b0;
    acc_step_d = 1'b0;
    done_d     = 1'b0;
    x_val_d    = x_val;
    v_val_d    = v_val;
    a_val_d    = a_val;
    j_val_d    = j_val;

    if (abort) begin
      state_d = StIdle;
      flush   = 1'b1;
      rem_d   = '0;
      presc_d = '0;
      if (AutoStop) begin
        load_d  = 1'b1;
        set_v_d = 1'b1;
        set_a_d = 1'b1;
        set_j_d = 1'b1;
        v_val_d = '0;
        a_val_d = '0;
        j_val_d = '0;
      end
    end else begin
      unique case (state_q)
        StIdle: begin
          if (set_pos) begin
            load_d  = 1'b1;
            set_x_d = 1'b1;
            x_val_d = pos_val;
          end else if (start && count_q != '0) begin
            state_d = StLoad;
          end
        end
        StLoad: begin
          pop                        = 1'b1;
          load_d                     = 1'b1;
          {set_j_d, set_a_d, set_v_d} = flags_mem[rd_ptr_q];
          v_val_d                    = v_mem[rd_ptr_q];
          a_val_d                    = a_mem[rd_ptr_q];
          j_val_d                    = j_mem[rd_ptr_q];
          rem_d                      = dur_mem[rd_ptr_q];
          div_d                      = acc_div;
          presc_d                    = '0;
          // Zero-length segments apply their values and fall straight through.
          if (dur_mem[rd_ptr_q] != '0) begin
            state_d = StRun;
          end else if (count_q > OneCount) begin
            state_d = StLoad;
          end else begin
            state_d = StEnd;
          end
        end
        StRun: begin
          if (presc_q == div_q) begin
            acc_step_d = 1'b1;
            presc_d    = '0;
            rem_d      = rem_q - 32'd1;
            if (rem_q == 32'd1) begin
              state_d = (count_q != '0) ? StLoad : StEnd;
            end
          end else begin
            presc_d = presc_q + 16'd1;
          end
        end
        StEnd: begin
          done_d  = 1'b1;
          state_d = StIdle;
          if (AutoStop) begin
            load_d  = 1'b1;
            set_v_d = 1'b1;
            set_a_d = 1'b1;
            set_j_d = 1'b1;
            v_val_d = '0;
            a_val_d = '0;
            j_val_d = '0;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      rem_q    <= '0;
      div_q    <= '0;
      presc_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      seg_full <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      load     <= 1'b0;
      set_x    <= 1'b0;
      set_v    <= 1'b0;
      set_a    <= 1'b0;
      set_j    <= 1'b0;
      acc_step <= 1'b0;
      x_val    <= '0;
      v_val    <= '0;
      a_val    <= '0;
      j_val    <= '0;
    end else begin
      state_q  <= state_d;
      rem_q    <= rem_d;
      div_q    <= div_d;
      presc_q  <= presc_d;
      if (flush) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      count_q  <= count_d;
      seg_full <= (count_d == FullCount);
      busy     <= (state_d != StIdle);
      done     <= done_d;
      load     <= load_d;
      set_x    <= set_x_d;
      set_v    <= set_v_d;
      set_a    <= set_a_d;
      set_j    <= set_j_d;
      acc_step <= acc_step_d;
      x_val    <= x_val_d;
      v_val    <= v_val_d;
      a_val    <= a_val_d;
      j_val    <= j_val_d;
    end
  end

endmodule

// File: tb/tb_motion_segment_sequencer.sv
// Directed bench for motion_segment_sequencer; expectations are hand-derived cycle by cycle.
// Honours MOTION_SEQ_AUTOSTOP_EN when the design is built with it.
module tb_motion_segment_sequencer;

`ifdef MOTION_SEQ_AUTOSTOP_EN
  localparam bit AutoStop = 1'b1;
`else
  localparam bit AutoStop = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        seg_wr = 1'b0;
  logic [2:0]  seg_flags = '0;
  logic [31:0] seg_v = '0, seg_a = '0, seg_j = '0, seg_dur = '0;
  logic        seg_full;
  logic [2:0]  seg_count;
  logic        start = 1'b0, abort = 1'b0, set_pos = 1'b0;
  logic [63:0] pos_val = '0;
  logic [15:0] acc_div = '0;
  logic        busy, done, load, set_x, set_v, set_a, set_j, acc_step;
  logic [63:0] x_val;
  logic [31:0] v_val, a_val, j_val;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  motion_segment_sequencer #(.DEPTH(4), .AW(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .seg_wr    (seg_wr),
    .seg_flags (seg_flags),
    .seg_v     (seg_v),
    .seg_a     (seg_a),
    .seg_j     (seg_j),
    .seg_dur   (seg_dur),
    .seg_full  (seg_full),
    .seg_count (seg_count),
    .start     (start),
    .abort     (abort),
    .set_pos   (set_pos),
    .pos_val   (pos_val),
    .acc_div   (acc_div),
    .busy      (busy),
    .done      (done),
    .load      (load),
    .set_x     (set_x),
    .set_v     (set_v),
    .set_a     (set_a),
    .set_j     (set_j),
    .x_val     (x_val),
    .v_val     (v_val),
    .a_val     (a_val),
    .j_val     (j_val),
    .acc_step  (acc_step)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nvec++;
    assert (got === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic push(input logic [2:0] f, input logic [31:0] v, input logic [31:0] a,
                      input logic [31:0] j, input logic [31:0] d);
    seg_wr = 1'b1; seg_flags = f; seg_v = v; seg_a = a; seg_j = j; seg_dur = d;
    tick();
    seg_wr = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    logic [15:0] exp_step, exp_load, exp_done;
    logic [31:0] got_v [8];
    int n, steps, dones, loads;

    tick(); tick();
    reset = 1'b0;
    chk("rst_load", load, 0);
    chk("rst_busy", busy, 0);
    chk("rst_count", seg_count, 0);
    chk("rst_full", seg_full, 0);
    chk("rst_xval", x_val, 0);
    chk("rst_step", acc_step, 0);

    // Reset pulse in the middle of a long segment
    acc_div = 16'd0;
    push(3'b001, 32'h33, 0, 0, 100);
    pulse_start();
    tick();
    chk("t1_load", load, 1);
    chk("t1_v", v_val, 32'h33);
    tick(); tick();
    chk("t1_busy_pre", busy, 1);
    #2 reset = 1'b1;
    #1;
    chk("t1_busy", busy, 0);
    chk("t1_count", seg_count, 0);
    chk("t1_step", acc_step, 0);
    chk("t1_v_clr", v_val, 0);
    chk("t1_load_clr", load, 0);
    reset = 1'b0;
    tick();
    chk("t1_busy_post", busy, 0);

    // Single segment, div=9, 4 ticks; acc_div change mid-run must be ignored
    acc_div = 16'd9;
    push(3'b011, 5, 1, 0, 4);
    chk("t2_count", seg_count, 1);
    pulse_start();
    chk("t2_busy", busy, 1);
    tick();
    chk("t2_load", load, 1);
    chk("t2_v", v_val, 5);
    chk("t2_a", a_val, 1);
    chk("t2_setv", set_v, 1);
    chk("t2_seta", set_a, 1);
    chk("t2_setj", set_j, 0);
    chk("t2_setx", set_x, 0);
    for (int c = 1; c <= 45; c++) begin
      tick();
      if (c == 15) acc_div = 16'd3;
      chk("t2_step", acc_step, (c % 10 == 0) && (c <= 40));
      chk("t2_done", done, c == 41);
      chk("t2_load_run", load, AutoStop && (c == 41));
      if (c == 40) chk("t2_busy_hi", busy, 1);
      if (c == 41) chk("t2_busy_lo", busy, 0);
    end

    // Two chained segments with div=0
    acc_div = 16'd0;
    push(3'b001, 7, 0, 0, 2);
    push(3'b100, 0, 0, 9, 3);
    pulse_start();
    tick();
    chk("t3_load0", load, 1);
    chk("t3_v0", v_val, 7);
    exp_step = 16'h0076;
    exp_load = 16'h0008;
    exp_done = 16'h0080;
    steps = 0;
    dones = 0;
    for (int c = 1; c <= 10; c++) begin
      tick();
      steps += int'(acc_step);
      dones += int'(done);
      chk("t3_step", acc_step, exp_step[c]);
      chk("t3_done", done, exp_done[c]);
      chk("t3_load", load, exp_load[c] | (AutoStop & exp_done[c]));
      if (c == 3) begin
        chk("t3_j", j_val, 9);
        chk("t3_setj", set_j, 1);
        chk("t3_setv", set_v, 0);
      end
    end
    chk("t3_nsteps", steps, 5);
    chk("t3_ndone", dones, 1);

    // FIFO full: drop while idle, accept when popped in the same cycle
    for (int i = 1; i <= 4; i++) push(3'b001, i, 0, 0, 1);
    chk("t4_full", seg_full, 1);
    chk("t4_count", seg_count, 4);
    push(3'b001, 32'h99, 0, 0, 1);
    chk("t4_count_drop", seg_count, 4);
    chk("t4_full_drop", seg_full, 1);
    start = 1'b1;
    tick();
    start = 1'b0;
    push(3'b001, 32'h55, 0, 0, 1);
    chk("t4_count_pop", seg_count, 4);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      if (load && !done && n < 8) begin
        got_v[n] = v_val;
        n++;
      end
      if (done) break;
      tick();
    end
    chk("t4_nloads", n, 5);
    chk("t4_v0", got_v[0], 1);
    chk("t4_v1", got_v[1], 2);
    chk("t4_v2", got_v[2], 3);
    chk("t4_v3", got_v[3], 4);
    chk("t4_v4", got_v[4], 32'h55);
    chk("t4_empty", seg_count, 0);

    // Zero-duration segment falls through to the next load
    push(3'b001, 32'hA, 0, 0, 0);
    push(3'b001, 32'hB, 0, 0, 1);
    pulse_start();
    tick();
    chk("t0_loadA", load, 1);
    chk("t0_vA", v_val, 32'hA);
    tick();
    chk("t0_loadB", load, 1);
    chk("t0_vB", v_val, 32'hB);
    chk("t0_nostep", acc_step, 0);
    tick();
    chk("t0_step", acc_step, 1);
    chk("t0_noload", load, 0);
    tick();
    chk("t0_done", done, 1);

    // set_pos in idle beats start; ignored while busy
    push(3'b001, 1, 0, 0, 100);
    pos_val = 64'h1_0000_0000;
    set_pos = 1'b1;
    start   = 1'b1;
    tick();
    set_pos = 1'b0;
    start   = 1'b0;
    chk("t5_load", load, 1);
    chk("t5_setx", set_x, 1);
    chk("t5_xval", x_val, 64'h1_0000_0000);
    chk("t5_setv", set_v, 0);
    chk("t5_busy", busy, 0);
    tick();
    chk("t5_busy_still", busy, 0);
    pulse_start();
    tick();
    chk("t5_load_seg", load, 1);
    chk("t5_setx_seg", set_x, 0);
    pos_val = 64'hDEAD;
    set_pos = 1'b1;
    tick();
    set_pos = 1'b0;
    chk("t5_busy_load", load, 0);
    chk("t5_busy_xval", x_val, 64'h1_0000_0000);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("t5_abort_busy", busy, 0);
    chk("t5_abort_count", seg_count, 0);

    // Abort during the first of three segments, with a push in the abort cycle
    acc_div = 16'd1;
    push(3'b001, 1, 0, 0, 5);
    push(3'b001, 2, 0, 0, 5);
    push(3'b001, 3, 0, 0, 5);
    pulse_start();
    tick();
    chk("t6_load", load, 1);
    tick(); tick();
    chk("t6_step", acc_step, 1);
    tick();
    abort  = 1'b1;
    seg_wr = 1'b1;
    seg_v  = 32'h77;
    tick();
    abort  = 1'b0;
    seg_wr = 1'b0;
    chk("t6_nostep", acc_step, 0);
    chk("t6_nodone", done, 0);
    chk("t6_count", seg_count, 0);
    chk("t6_busy", busy, 0);
    chk("t6_load", load, AutoStop);
    if (AutoStop) begin
      chk("t6_setv", set_v, 1);
      chk("t6_seta", set_a, 1);
      chk("t6_setj", set_j, 1);
      chk("t6_v0", v_val, 0);
      chk("t6_a0", a_val, 0);
      chk("t6_j0", j_val, 0);
    end
    steps = 0;
    dones = 0;
    loads = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      steps += int'(acc_step);
      dones += int'(done);
      loads += int'(load);
    end
    chk("t6_quiet_step", steps, 0);
    chk("t6_quiet_done", dones, 0);
    chk("t6_quiet_load", loads, 0);
    chk("t6_quiet_count", seg_count, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/motion_segment_sequencer.md
Name: motion_segment_sequencer

Overview:
Sequences an acc_profile_gen instance through a queue of motion segments.
- Software pushes segments (v/a/j values, set-flags, duration in acc_step ticks) into a small internal FIFO.
- The sequencer loads each segment into the generator at the segment boundary and issues acc_step pulses at a programmable cycle divider.
- It counts the duration down and chains to the next segment with no gap.
- Sits between the bus register block and acc_profile_gen inside the motion core.

Parameters:
DEPTH, 4, FIFO depth in segments (power of two, >=2)
AW, 2, log2(DEPTH)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
seg_wr  in  1  push one segment (single-cycle strobe)
seg_flags  in  3  {set_j,set_a,set_v} for the pushed segment
seg_v  in  32  velocity value
seg_a  in  32  acceleration value
seg_j  in  32  jerk value
seg_dur  in  32  segment length in acc_step ticks
seg_full  out  1  FIFO full
seg_count  out  AW+1  entries queued
start  in  1  begin executing queue
abort  in  1  stop immediately and flush the queue
set_pos  in  1  preload position (honoured only in IDLE)
pos_val  in  64  position for preload
acc_div  in  16  acc_step period minus one, in clk cycles
busy  out  1  state != IDLE
done  out  1  one-cycle pulse when the queue completes
load  out  1  to acc_profile_gen.load
set_x  out  1  to acc_profile_gen.set_x
set_v  out  1  to acc_profile_gen.set_v
set_a  out  1  to acc_profile_gen.set_a
set_j  out  1  to acc_profile_gen.set_j
x_val  out  64  to acc_profile_gen.x_val
v_val  out  32  to acc_profile_gen.v_val
a_val  out  32  to acc_profile_gen.a_val
j_val  out  32  to acc_profile_gen.j_val
acc_step  out  1  to acc_profile_gen.acc_step

Behaviour:
Reset (asynchronous, active-high):
- All outputs 0; FIFO empty; state IDLE.
- Clearing reset takes effect at the next clk edge.

General:
- All outputs registered.
- load, set_*, acc_step and done are single-cycle pulses.
- x_val/v_val/a_val/j_val hold their last driven value.

FIFO:
- seg_wr while full and no pop in the same cycle: write dropped, no other effect.
- seg_wr while full with a pop in the same cycle: write accepted.
- seg_wr into an empty FIFO while in LOAD: not visible until the next LOAD decision.

States:
IDLE
- set_pos: next cycle load=1, set_x=1, x_val=pos_val, other set_*=0.
- start with FIFO non-empty: go to LOAD.
- start with FIFO empty: ignored.
- set_pos and start in the same cycle: set_pos wins; start ignored.

LOAD (1 cycle)
- Pop the head entry.
- Drive load=1, set_v/a/j=flags, v/a/j_val=entry values, set_x=0.
- Latch remaining=dur and div=acc_div; clear prescaler.
- dur!=0: go to RUN.
- dur==0 with FIFO non-empty: go to LOAD next cycle (segment applied, zero ticks).
- dur==0 with FIFO empty: go to END.

RUN
- Prescaler counts 0..div; at terminal count acc_step=1, prescaler wraps, remaining decrements.
- First acc_step comes div+1 cycles after the load cycle; period is div+1 cycles (div=0 gives acc_step every cycle).
- After the acc_step that brings remaining to 0: go to LOAD if FIFO non-empty, else END.
- The next load occurs in the cycle immediately after the last acc_step.
- start is ignored outside IDLE.
- acc_div changes take effect only at the next LOAD.

END (1 cycle)
- done=1, then go to IDLE.

abort:
- Highest priority in any state.
- Next state IDLE; FIFO flushed; prescaler and remaining cleared.
- No load, acc_step or done is issued in the following cycle.
- seg_wr in the same cycle as abort is dropped.

Width rules:
- remaining is 32-bit unsigned; prescaler is 16-bit.
- No wrap-around is possible since remaining is checked before decrement.

Optional Feature:
MOTION_SEQ_AUTOSTOP_EN
- Defined: on queue exhaustion the END cycle also drives load=1, set_v=set_a=set_j=1, v/a/j_val=0, so the generator stops.
- Defined: abort issues the same zeroing load in the cycle after abort; the FIFO is still flushed.
- Undefined: END only pulses done; generator values are untouched; abort issues no load.

Test Plan:
1. Reset mid-RUN (seg dur=100), assert reset for 1 ns off-edge -> all outputs 0 immediately, seg_count=0, busy=0.
2. Push {flags=011,v=5,a=1,dur=4}, acc_div=9, start -> load with v_val=5,a_val=1; 4 acc_step pulses at cycles +10,+20,+30,+40 after load; done one cycle after the 4th; busy falls.
3. Push two segments (dur=2, dur=3), acc_div=0 -> second load in the cycle right after the 2nd acc_step; 5 acc_steps total; exactly one done.
4. Fill FIFO (4 pushes), 5th push while IDLE -> seg_full=1, seg_count=4, 5th dropped; start then pops, and a push in the pop cycle is accepted (count stays 4).
5. set_pos with pos_val=0x1_0000_0000 in IDLE -> load=1,set_x=1,x_val=0x1_0000_0000; set_pos while busy -> no load.
6. abort during RUN of segment 1 of 3 -> no further acc_step, seg_count=0, done never pulses. With MOTION_SEQ_AUTOSTOP_EN: one load with v/a/j=0, all three set_* high.
